// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq
// Description : Multi-cycle unsigned multiply / divide sequencer that borrows
//               the shared 32-bit datapath ALU. MULU (low word only) is built
//               by shift-add, one bit per cycle; DIVU is restoring division
//               using a compare (SLTU) cycle followed by a subtract cycle per
//               quotient bit. The pipeline is held via busy until done.
//
// Ports       : clk, rst          clock, synchronous active-high reset
//               start, op         request strobe (IDLE only), 0=MULU 1=DIVU
//               op_a, op_b        operands, captured at accept
//               busy, done        hold-pipeline flag, one-cycle completion
//               result_lo/hi      MULU: {0, product}; DIVU: {rem, quotient}
//               div_by_zero       DIVU with op_b == 0
//               alu_a/b/sel       operands and select driven to the ALU
//               alu_out/zero      ALU result and zero flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    localparam int             c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_first = '0;
    localparam logic [WIDTH-1:0]   c_one   = WIDTH'(1);

    localparam logic [2:0] c_sel_add  = 3'd0;
    localparam logic [2:0] c_sel_sub  = 3'd1;
    localparam logic [2:0] c_sel_sltu = 3'd4;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_mul     = 3'd1;
    localparam logic [2:0] c_st_div_cmp = 3'd2;
    localparam logic [2:0] c_st_div_sub = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [c_cnt_w-1:0] r_i;
    logic               r_ge;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic               r_dbz;

    logic               w_div_zero;
    logic [WIDTH-1:0]   w_rem_sh;
    logic [WIDTH-1:0]   w_mul_addend;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_rem_nxt;

    assign w_div_zero   = op && (op_b == '0);
    // Partial remainder with the next dividend bit shifted in. Its dropped MSB
    // (r_rem[WIDTH-1]) means the true 33-bit value already exceeds the divisor.
    assign w_rem_sh     = {r_rem[WIDTH-2:0], r_a[r_i]};
    assign w_mul_addend = r_b[r_i] ? (r_a << r_i) : '0;
    assign w_quo_nxt    = r_ge ? (r_quo | (c_one << r_i)) : r_quo;
    // When the overflow bit was set the wrapped subtraction is still exact,
    // because the real difference is below 2^WIDTH.
    assign w_rem_nxt    = r_ge ? alu_out : w_rem_sh;

    assign busy        = (r_state != c_st_idle);
    assign done        = (r_state == c_st_done);
    assign result_lo   = r_lo;
    assign result_hi   = r_hi;
    assign div_by_zero = r_dbz;

    always_comb begin
        w_next_state = r_state;
        alu_a        = '0;
        alu_b        = '0;
        alu_sel      = c_sel_add;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    if (w_div_zero) begin
                        w_next_state = c_st_done;
                    end else if (op) begin
                        w_next_state = c_st_div_cmp;
                    end else begin
                        w_next_state = c_st_mul;
                    end
                end
            end
            c_st_mul: begin
                alu_sel = c_sel_add;
                alu_a   = r_acc;
                alu_b   = w_mul_addend;
                if (r_i == c_last) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_div_cmp: begin
                alu_sel      = c_sel_sltu;
                alu_a        = w_rem_sh;
                alu_b        = r_b;
                w_next_state = c_st_div_sub;
            end
            c_st_div_sub: begin
                alu_sel      = c_sel_sub;
                alu_a        = w_rem_sh;
                alu_b        = r_b;
                w_next_state = (r_i == c_first) ? c_st_done : c_st_div_cmp;
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_i     <= '0;
            r_ge    <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a   <= op_a;
                        r_b   <= op_b;
                        r_acc <= '0;
                        r_rem <= '0;
                        r_quo <= '0;
                        r_ge  <= 1'b0;
                        r_i   <= op ? c_last : c_first;
                        if (w_div_zero) begin
                            r_lo  <= '1;
                            r_hi  <= op_a;
                            r_dbz <= 1'b1;
                        end else begin
                            r_lo  <= '0;
                            r_hi  <= '0;
                            r_dbz <= 1'b0;
                        end
                    end
                end
                c_st_mul: begin
                    r_acc <= alu_out;
                    r_i   <= r_i + c_cnt_w'(1);
                    // Results land on the edge into DONE so they are valid
                    // while done is high.
                    if (r_i == c_last) begin
                        r_lo <= alu_out;
                        r_hi <= '0;
                    end
                end
                c_st_div_cmp: begin
                    // SLTU returns 0 (zero flag) when rem' >= divisor.
                    r_ge <= alu_zero | r_rem[WIDTH-1];
                end
                c_st_div_sub: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (r_i == c_first) begin
                        r_lo <= w_quo_nxt;
                        r_hi <= w_rem_nxt;
                    end else begin
                        r_i <= r_i - c_cnt_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_seq
// Description : Self-checking bench for alu_muldiv_seq. Provides the
//               combinational ALU, a latency/result model computed with
//               plain arithmetic, a per-cycle compare process and directed
//               vectors with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        div_by_zero;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_sel;
    logic [31:0] alu_out;
    logic        alu_zero;

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero)
    );

    // Datapath ALU
    always_comb begin
        alu_out = '0;
        case (alu_sel)
            3'd0:    alu_out = alu_a + alu_b;
            3'd1:    alu_out = alu_a - alu_b;
            3'd4:    alu_out = {31'b0, (alu_a < alu_b)};
            default: alu_out = '0;
        endcase
    end
    assign alu_zero = (alu_out == '0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model: latency per operation and final values from
    // ordinary arithmetic.
    logic        m_active = 1'b0;
    int          m_cyc = 0;
    int          m_lat = 0;
    logic        m_op = 1'b0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_hi = '0;
    logic        m_dbz = 1'b0;
    logic [31:0] f_lo = '0;
    logic [31:0] f_hi = '0;
    logic        f_dbz = 1'b0;
    logic [63:0] t_prod;
    logic [31:0] t_lo;
    logic [31:0] t_hi;
    logic        t_dbz;
    int          t_lat;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_cyc    <= 0;
            m_lo     <= '0;
            m_hi     <= '0;
            m_dbz    <= 1'b0;
        end else if (!m_active) begin
            if (start) begin
                if (!op) begin
                    t_prod = {32'b0, op_a} * {32'b0, op_b};
                    t_lo   = t_prod[31:0];
                    t_hi   = '0;
                    t_dbz  = 1'b0;
                    t_lat  = 33;
                end else if (op_b == 32'd0) begin
                    t_lo  = 32'hFFFF_FFFF;
                    t_hi  = op_a;
                    t_dbz = 1'b1;
                    t_lat = 1;
                end else begin
                    t_lo  = op_a / op_b;
                    t_hi  = op_a % op_b;
                    t_dbz = 1'b0;
                    t_lat = 65;
                end
                m_active <= 1'b1;
                m_cyc    <= 1;
                m_lat    <= t_lat;
                m_op     <= op;
                f_lo     <= t_lo;
                f_hi     <= t_hi;
                f_dbz    <= t_dbz;
                if (t_lat == 1) begin
                    m_lo  <= t_lo;
                    m_hi  <= t_hi;
                    m_dbz <= t_dbz;
                end else begin
                    m_lo  <= '0;
                    m_hi  <= '0;
                    m_dbz <= 1'b0;
                end
            end
        end else begin
            if (m_cyc == m_lat) begin
                m_active <= 1'b0;
            end else begin
                m_cyc <= m_cyc + 1;
                if (m_cyc + 1 == m_lat) begin
                    m_lo  <= f_lo;
                    m_hi  <= f_hi;
                    m_dbz <= f_dbz;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_active && (m_cyc == m_lat)));
            chk("result_lo", result_lo, m_lo);
            chk("result_hi", result_hi, m_hi);
            chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
            if (!m_active) begin
                chk("idle alu_a", alu_a, 32'd0);
                chk("idle alu_b", alu_b, 32'd0);
                chk("idle alu_sel", 32'(alu_sel), 32'd0);
            end else if (m_cyc < m_lat) begin
                chk("alu_sel", 32'(alu_sel),
                    m_op ? ((m_cyc % 2 == 1) ? 32'd4 : 32'd1) : 32'd0);
            end
        end
    end

    task automatic run_op(input string nm, input logic o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] elo,
                          input logic [31:0] ehi, input logic edbz, input int elat);
        int n;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'(elat));
        chk({nm, " lo"}, result_lo, elo);
        chk({nm, " hi"}, result_hi, ehi);
        chk({nm, " dbz"}, 32'(div_by_zero), 32'(edbz));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        int second;
        @(posedge clk);
        #1 cmp_en = 1'b1;
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result_lo", result_lo, 32'd0);
        chk("reset alu_sel", 32'(alu_sel), 32'd0);
        rst = 1'b0;

        run_op("mul 7x6", 1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0, 33);
        run_op("mul wrap", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'd0, 1'b0, 33);
        run_op("mul zero", 1'b0, 32'd0, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 33);
        run_op("div 100/7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 65);
        run_op("div ov", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 65);
        run_op("div 5/9", 1'b1, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 65);
        run_op("div by 0", 1'b1, 32'd123, 32'd0, 32'hFFFF_FFFF, 32'd123, 1'b1, 1);

        // start held high through a multiply
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        op_a  = 32'd3;
        op_b  = 32'd5;
        ndone  = 0;
        second = 0;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 2) second = c;
            end
            if (c == 40) start = 1'b0;
        end
        chk("held start done count", 32'(ndone), 32'd2);
        chk("held start second done cycle", 32'(second), 32'd67);
        chk("held start lo", result_lo, 32'd15);

        // reset in cycle 20 of a divide
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        op_a  = 32'd1000;
        op_b  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 20; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort alu_a", alu_a, 32'd0);
        ndone = 0;
        for (int c = 0; c < 70; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort no done", 32'(ndone), 32'd0);
        run_op("div after abort", 1'b1, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 65);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
